// File: rtl/sum_accum.sv
// Accumulator behind the 8-bit adder: synchronised sample edges add sum_in into a 16-bit total.
// Optional macro SUM_ACCUM_SAT_EN selects a saturating accumulator instead of a wrapping one.
module sum_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sum_in,
  input  logic       sample_in,
  input  logic       clr,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCapt, StAdd} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             sample_edge;
  logic [7:0]       hold_q, hold_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             miss_q, miss_d;
  logic             ovf_q, ovf_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic [16:0]      acc_sum;
  logic [CNT_W+7:0] count_ext;

  // The synchroniser keeps running while disabled so stale edges age out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sample_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sample_edge = s2_q & ~s3_q;
  assign acc_sum     = {1'b0, acc_q} + {9'b0, hold_q};
  assign busy        = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    acc_d     = acc_q;
    count_d   = count_q;
    miss_d    = miss_q;
    ovf_d     = ovf_q;
    cnt_sat_d = cnt_sat_q;
    if (clr) begin
      state_d   = StIdle;
      hold_d    = 8'h00;
      acc_d     = 16'h0000;
      count_d   = '0;
      miss_d    = 1'b0;
      ovf_d     = 1'b0;
      cnt_sat_d = 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (sample_edge) begin
            state_d = StCapt;
            hold_d  = sum_in;
          end
        end
        StCapt: begin
          state_d = StAdd;
          if (sample_edge) miss_d = 1'b1;
        end
        StAdd: begin
          state_d = StIdle;
          if (sample_edge) miss_d = 1'b1;
`ifdef SUM_ACCUM_SAT_EN
          if (acc_sum[16]) begin
            acc_d = 16'hFFFF;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum[15:0];
          end
`else
          acc_d = acc_sum[15:0];
          if (acc_sum[16]) ovf_d = 1'b1;
`endif
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          if (count_d == '1) cnt_sat_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= 8'h00;
      acc_q     <= 16'h0000;
      count_q   <= '0;
      miss_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      miss_q    <= miss_d;
      ovf_q     <= ovf_d;
      cnt_sat_q <= cnt_sat_d;
    end
  end

  // Padding lets the low byte be taken for any counter width.
  assign count_ext = {8'h00, count_q};

  always_comb begin
    rd_data = 8'h00;
    unique case (rd_sel)
      2'd0: rd_data = acc_q[7:0];
      2'd1: rd_data = acc_q[15:8];
      2'd2: rd_data = count_ext[7:0];
      2'd3: rd_data = {4'b0000, busy, cnt_sat_q, miss_q, ovf_q};
      default: rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed, table-driven bench for sum_accum; expected values are hand-computed constants.
module tb_sum_accum;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] sum_in;
  logic       sample_in;
  logic       clr;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  sum;
    logic [15:0] acc;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[5];

  sum_accum #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sum_in    (sum_in),
    .sample_in (sample_in),
    .clr       (clr),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic read_byte(input logic [1:0] sel, output logic [7:0] data);
    rd_sel = sel;
    #1;
    data = rd_data;
  endtask

  task automatic check_regs(input string name, input logic [15:0] acc, input logic [7:0] cnt,
                            input logic [7:0] status);
    logic [7:0] d;
    read_byte(2'd0, d);
    check({name, " acc_lo"}, {8'h00, d}, {8'h00, acc[7:0]});
    read_byte(2'd1, d);
    check({name, " acc_hi"}, {8'h00, d}, {8'h00, acc[15:8]});
    read_byte(2'd2, d);
    check({name, " count"}, {8'h00, d}, {8'h00, cnt});
    read_byte(2'd3, d);
    check({name, " status"}, {8'h00, d}, {8'h00, status});
  endtask

  // Called at a negedge; 4-cycle pulse, returns number of sampled busy cycles.
  task automatic do_sample(input logic [7:0] val, output int busy_cycles);
    sum_in      = val;
    sample_in   = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (i == 3) sample_in = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int         b;
    logic [7:0] d;
    logic [15:0] ovf_acc;

    vecs[0] = '{sum: 8'h2A, acc: 16'h002A, cnt: 8'd1};
    vecs[1] = '{sum: 8'h80, acc: 16'h00AA, cnt: 8'd2};
    vecs[2] = '{sum: 8'hFF, acc: 16'h01A9, cnt: 8'd3};
    vecs[3] = '{sum: 8'h00, acc: 16'h01A9, cnt: 8'd4};
    vecs[4] = '{sum: 8'h57, acc: 16'h0200, cnt: 8'd5};

    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; sample_in = 1'b0; sum_in = 8'h00; rd_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Build some state, then reset asynchronously mid-cycle.
    do_sample(8'h2A, b);
    @(posedge clk);
    #3 rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      read_byte(2'(s), d);
      check($sformatf("reset rd_sel%0d", s), {8'h00, d}, 16'h0000);
    end
    check("reset busy", {15'h0, busy}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_sample(vecs[i].sum, b);
      check($sformatf("vec%0d busy_cycles", i), 16'(b), 16'd2);
      check_regs($sformatf("vec%0d", i), vecs[i].acc, vecs[i].cnt, 8'h00);
    end

    // Clear while in ADD discards the pending add.
    sum_in = 8'h77; sample_in = 1'b1;
    repeat (4) @(negedge clk);
    check("clr in_add busy", {15'h0, busy}, 16'h0001);
    clr = 1'b1; sample_in = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check("clr busy", {15'h0, busy}, 16'h0000);
    check_regs("clr", 16'h0000, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    check_regs("clr late", 16'h0000, 8'h00, 8'h00);

    // Second edge while busy is dropped and sets miss.
    sum_in = 8'h10; sample_in = 1'b1;
    @(negedge clk); sample_in = 1'b0;
    @(negedge clk); sample_in = 1'b1;
    @(negedge clk); sample_in = 1'b0;
    repeat (6) @(negedge clk);
    check_regs("b2b", 16'h0010, 8'h01, 8'h02);

    // Edge while disabled is dropped without miss.
    pulse_clr();
    ena = 1'b0; sum_in = 8'h44; sample_in = 1'b1;
    repeat (4) @(negedge clk);
    ena = 1'b1; sample_in = 1'b0;
    repeat (4) @(negedge clk);
    check_regs("ena drop", 16'h0000, 8'h00, 8'h00);

    // Disable while in CAPT stalls; completes 2 cycles after re-enable.
    sum_in = 8'h33; sample_in = 1'b1;
    repeat (3) @(negedge clk);
    check("stall capt busy", {15'h0, busy}, 16'h0001);
    ena = 1'b0; sample_in = 1'b0;
    repeat (3) @(negedge clk);
    check("stall held busy", {15'h0, busy}, 16'h0001);
    read_byte(2'd0, d);
    check("stall held acc", {8'h00, d}, 16'h0000);
    ena = 1'b1;
    @(negedge clk);
    check("stall add busy", {15'h0, busy}, 16'h0001);
    read_byte(2'd0, d);
    check("stall add acc", {8'h00, d}, 16'h0000);
    @(negedge clk);
    check("stall done busy", {15'h0, busy}, 16'h0000);
    check_regs("stall done", 16'h0033, 8'h01, 8'h00);

    // 258 x 0xFF: counter saturates, accumulator overflows.
    pulse_clr();
    for (int i = 0; i < 258; i++) do_sample(8'hFF, b);
`ifdef SUM_ACCUM_SAT_EN
    ovf_acc = 16'hFFFF;
`else
    ovf_acc = 16'h00FE;
`endif
    check_regs("overflow", ovf_acc, 8'hFF, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
# sum_accum

Accumulator stage that sits directly downstream of the top-level 8-bit adder (`ui_in + uio_in`). On each synchronised rising edge of a sample pin, it captures the adder result and adds it into a 16-bit running total. It also keeps a sample count and sticky status flags. One byte at a time, selected by `rd_sel`, is presented for the top level to route to `uo_out` or `uio_out`.

## Interface
Parameters:
- `CNT_W`, 8 — sample counter width; the read mux exposes the low 8 bits.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: block enable; when low, the FSM holds its state.
- `sum_in` input 8: adder result, `ui_in + uio_in` truncated to 8 bits.
- `sample_in` input 1: asynchronous pin; a rising edge requests one accumulation.
- `clr` input 1: synchronous clear, active high.
- `rd_sel` input 2: read byte select.
- `rd_data` output 8: selected byte, combinational mux of registered state.
- `busy` output 1: high while the FSM is in CAPT or ADD.

## Operation
Input conditioning:
- `sample_in` passes through a two-flop synchroniser `s1`→`s2`, followed by history flop `s3`.
- `edge` = `s2 & ~s3`.
- The synchroniser runs regardless of `ena`.

FSM states and transitions:
- IDLE → CAPT when `edge & ena`. On that transition, `hold` ← `sum_in`.
- CAPT → ADD unconditionally when `ena`.
- ADD → IDLE when `ena`. On that transition, `acc` ← `acc + hold` and `count` ← `count + 1`.
- When `ena` is low, the FSM and all registers hold.
- Edges seen while `ena` is low are dropped. They do not set `miss`.

Boundary rules:
- Edge while `busy`: the edge is dropped and sticky `miss` is set.
- `count` saturates at all-ones; `cnt_sat` is set sticky when `count` reaches the maximum.
- `clr` has highest priority below reset. It zeroes `acc`, `count`, `hold` and all flags, and forces IDLE, even mid-ADD; the pending add is discarded.
- `clr` and `edge` in the same cycle: the clear wins and the edge is dropped without setting `miss`.
- Addition: `hold` is zero-extended to 16 bits; the carry out of bit 15 is handled as described in Configuration.

Read mux (`rd_sel`):
- 0: `acc[7:0]`
- 1: `acc[15:8]`
- 2: `count[7:0]`
- 3: status `{4'b0, busy, cnt_sat, miss, ovf}`

Reset values:
- `acc`, `count`, `hold`, `s1`, `s2`, `s3` and all flags are 0.
- FSM is in IDLE and `busy` = 0.
- `rd_data` = 0 for every `rd_sel`.

## Timing
- `sample_in` is first sampled high at posedge N, so `s1` = 1 at N.
- `s2` = 1 at N+1, and `edge` is high during the following cycle.
- Posedge N+2: FSM enters CAPT and `hold` is loaded from the `sum_in` value present before N+2.
- Posedge N+3: FSM enters ADD.
- Posedge N+4: `acc` and `count` are updated and the FSM is back in IDLE.
- Minimum spacing between accepted samples is 3 cycles; `busy` is high after N+2 and after N+3.
- `sample_in` must stay high for at least 2 cycles to be guaranteed to register.
- Each edge produces exactly one accumulation, independent of pulse length.
- `rd_data` changes in the same cycle as `rd_sel` (combinational); register contents update only on clock edges.

## Configuration
- `SUM_ACCUM_SAT_EN` defined:
  - `acc` saturates at 0xFFFF.
  - Any add whose true result exceeds 0xFFFF leaves `acc` = 0xFFFF and sets sticky `ovf`.
- `SUM_ACCUM_SAT_EN` undefined:
  - `acc` wraps modulo 2^16.
  - Carry out of bit 15 sets sticky `ovf`.
- Both builds keep identical ports and status layout.

## Test plan
- **Reset:** assert `rst_n` = 0 asynchronously mid-cycle, sweep `rd_sel` 0..3 → `rd_data` = 0x00 for all four values and `busy` = 0.
- **Single sample:** `sum_in` = 0x2A, one 4-cycle `sample_in` pulse → `busy` is high for exactly 2 cycles; afterwards `rd_sel` 0/1/2/3 read 0x2A/0x00/0x01/0x00.
- **Back-to-back pulses:** second `sample_in` edge arrives 1 cycle after the first is accepted, `sum_in` = 0x10 → only one add; `acc` = 0x0010, `count` = 1, status = 0x02 (`miss`).
- **Overflow:** 258 samples of 0xFF → with `SUM_ACCUM_SAT_EN`, `acc` = 0xFFFF and `ovf` = 1; without it, `acc` = 0x00FE (258 × 0xFF mod 2^16) and `ovf` = 1; in both builds `count` = 0xFF and `cnt_sat` = 1.
- **Clear mid-operation:** assert `clr` in the cycle the FSM is in ADD → `acc` keeps no update and reads 0, FSM is in IDLE, status = 0x00.
- **Enable gating:** `ena` = 0 during a `sample_in` edge → no add and `miss` = 0; `ena` = 0 while in CAPT stalls the FSM, and completion follows 2 cycles after `ena` returns high.
